cdb_rr_arbiter: RTL
===================

Name: cdb_rr_arbiter

Overview:
- Parametrised common-data-bus arbiter, the successor to the fixed adder/multiplier/memory CDB.
- Accepts results from NUM_SRC functional-unit channels, each through a per-channel skid queue with valid/ready backpressure.
- Broadcasts one result per cycle on a registered CDB using round-robin arbitration.
- Wide results (e.g. MUL low and MULH high words) are sent as two locked, consecutive beats.

Parameters:
NUM_SRC, 4, number of producer channels (2..8)
DATA_WIDTH, 32, result word width
TAG_WIDTH, 4, reservation-station tag width
QDEPTH, 2, entries per channel queue (power of 2, >=2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  NUM_SRC  per-channel result valid
in_ready  out  NUM_SRC  per-channel queue can accept
in_wide  in  NUM_SRC  result has a high word (two-beat broadcast)
in_tag  in  NUM_SRC*TAG_WIDTH  packed tags, channel i at [i*TAG_WIDTH +: TAG_WIDTH]
in_data  in  NUM_SRC*DATA_WIDTH  packed low words
in_data_hi  in  NUM_SRC*DATA_WIDTH  packed high words (ignored unless in_wide)
cdb_valid  out  1  broadcast valid
cdb_tag  out  TAG_WIDTH  broadcast tag
cdb_data  out  DATA_WIDTH  broadcast word
cdb_hi  out  1  0 = low or only beat, 1 = high beat of a wide result
cdb_src  out  $clog2(NUM_SRC)  winning channel index

Behaviour:
- Reset (reset=0, asynchronous):
  - all queues emptied and the round-robin pointer set to 0;
  - FSM goes to IDLE;
  - cdb_valid, cdb_tag, cdb_data, cdb_hi and cdb_src are all 0;
  - in_ready is 0 while reset is asserted.
- Reset mid-operation drops all queued entries, including a half-sent wide result. No partial beat is emitted after reset is released.
- Push: a transfer occurs when in_valid[i]&&in_ready[i] at a rising edge. The entry {tag, lo, hi, wide} is written at the queue tail.
- in_ready[i] = (count[i] < QDEPTH), computed from the registered count.
  - A full queue deasserts ready even if it is being popped that cycle; there is no combinational ready-from-pop path.
- Arbitration (IDLE):
  - Candidates are the non-empty queue heads.
  - Winner is the first candidate at or after rr_ptr, searching upward modulo NUM_SRC.
  - Output registers load the winner head at the edge: cdb_valid=1, tag, data=lo, cdb_hi=0, cdb_src=winner.
  - With no candidate, cdb_valid=0 and the other outputs hold their previous values.
- Narrow winner: the head is popped at the same edge and rr_ptr becomes winner+1 (mod NUM_SRC).
- Wide winner: the FSM goes to SECOND and the head is not popped.
- SECOND:
  - Outputs load data=hi, cdb_hi=1, same tag and src; no arbitration takes place.
  - The head is popped, rr_ptr becomes winner+1 and the FSM returns to IDLE.
  - Pushes to any queue, including the locked one, continue while in SECOND.
- Latency without bypass: an entry pushed at edge k is first broadcast in the cycle after edge k+1 (2 cycles), provided it wins.
- Simultaneous push and pop on the same queue: count unchanged; the new entry goes to the tail.
- Queue pointers wrap modulo QDEPTH.
- Fairness: with all channels continuously non-empty, each channel wins once every NUM_SRC grant rounds.
  - A wide grant counts as one round and occupies two cycles.
- Tag value 0 is carried transparently; the block attaches no meaning to it.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- When defined, in IDLE a channel whose queue is empty and whose in_valid=1 (ready is necessarily 1) is also a candidate.
- If such a channel wins, its input drives the output registers directly at that edge, giving 1-cycle latency.
  - Narrow: the entry is never written to the queue.
  - Wide: the entry is written to the queue as head and the high beat follows from SECOND as normal.
- Round-robin order and all other rules are unchanged.
- When undefined, every result passes through its queue and the minimum latency is 2 cycles.

Test Plan:
- Single narrow result: NUM_SRC=4. Push ch2 tag=5, data=0x0000_00AA at edge 0 -> cycle after edge 1: cdb_valid=1, tag=5, data=0xAA, hi=0, src=2. Next cycle cdb_valid=0. With CDB_BYPASS_EN, the broadcast appears 1 cycle earlier.
- Round robin: all 4 channels push one narrow entry at the same edge (tags 1,2,3,4), rr_ptr=0 -> broadcasts tags 1,2,3,4 on 4 consecutive cycles. Repeating with rr_ptr=2 -> order 3,4,1,2.
- Wide result: ch1 pushes tag=7, lo=0x1111_1111, hi=0x2222_2222, while ch0 also holds tag=3 -> beats in order: tag3; tag7 lo with hi=0; tag7 hi with hi=1. No other channel is granted between the tag7 beats.
- Backpressure: QDEPTH=2, stall ch0 by keeping ch3 continuously valid with rr_ptr parked. Push 3 entries to ch0 -> in_ready[0]=0 after the second push. The third entry is held by the source and accepted only after a pop; no entry is lost and data order is preserved.
- Reset mid-wide: assert reset in the cycle the lo beat of tag=9 is on the CDB -> all outputs are 0 immediately (asynchronous). After release, no hi beat for tag 9 appears and cdb_valid stays 0 until a new push.
- Concurrent push/pop: hold ch0 count=1 and push while it is being granted for 6 cycles -> the count stays 1 and the broadcast tag sequence matches the push order exactly.

Source files
------------

// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_rr_arbiter
// Description : Common-data-bus arbiter. Each of NUM_SRC producer channels
//               feeds a small skid queue (valid/ready). One result per cycle
//               is broadcast on a registered CDB, chosen round-robin. Wide
//               results go out as two locked beats (low word, then high word).
//               Optional macro CDB_BYPASS_EN lets an empty-queue channel with
//               in_valid=1 compete directly for 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int QDEPTH     = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SRC-1:0]              in_valid,
    output logic [NUM_SRC-1:0]              in_ready,
    input  logic [NUM_SRC-1:0]              in_wide,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]    in_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   in_data_hi,
    output logic                            cdb_valid,
    output logic [TAG_WIDTH-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]           cdb_data,
    output logic                            cdb_hi,
    output logic [$clog2(NUM_SRC)-1:0]      cdb_src
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

    // ------------------------------------------------------------------
    // Queue storage and bookkeeping
    // ------------------------------------------------------------------
    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_SRC][QDEPTH];
    logic [DATA_WIDTH-1:0] lo_mem   [NUM_SRC][QDEPTH];
    logic [DATA_WIDTH-1:0] hi_mem   [NUM_SRC][QDEPTH];
    logic                  wide_mem [NUM_SRC][QDEPTH];

    logic [PW-1:0] wr_ptr_q [NUM_SRC];
    logic [PW-1:0] wr_ptr_d [NUM_SRC];
    logic [PW-1:0] rd_ptr_q [NUM_SRC];
    logic [PW-1:0] rd_ptr_d [NUM_SRC];
    logic [CW-1:0] cnt_q    [NUM_SRC];
    logic [CW-1:0] cnt_d    [NUM_SRC];

    // Unpacked views of the packed input buses and of the queue heads
    logic [TAG_WIDTH-1:0]  in_tag_a   [NUM_SRC];
    logic [DATA_WIDTH-1:0] in_lo_a    [NUM_SRC];
    logic [DATA_WIDTH-1:0] in_hi_a    [NUM_SRC];
    logic [TAG_WIDTH-1:0]  head_tag   [NUM_SRC];
    logic [DATA_WIDTH-1:0] head_lo    [NUM_SRC];
    logic [DATA_WIDTH-1:0] head_hi    [NUM_SRC];
    logic                  head_wide  [NUM_SRC];

    // ------------------------------------------------------------------
    // Arbitration / FSM state
    // ------------------------------------------------------------------
    logic [0:0]            state_q, state_d;
    logic [SW-1:0]         sec_src_q, sec_src_d;
    logic [SW-1:0]         rr_ptr_q, rr_ptr_d;

    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic                  cdb_hi_q, cdb_hi_d;
    logic [SW-1:0]         cdb_src_q, cdb_src_d;

    logic [NUM_SRC-1:0]    cand;
    logic                  win_found;
    logic [SW-1:0]         win_idx;
    logic                  win_byp;
    logic [TAG_WIDTH-1:0]  win_tag;
    logic [DATA_WIDTH-1:0] win_lo;
    logic                  win_wide;

    logic [NUM_SRC-1:0]    push_en;
    logic [NUM_SRC-1:0]    pop_en;

`ifdef CDB_BYPASS_EN
    logic [NUM_SRC-1:0]    byp_cand;
`endif

    // Ready comes only from the registered count; forced low during reset
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_ready[i] = reset & (cnt_q[i] < CW'(QDEPTH));
        end
    end

    // Slice the packed input buses and read out each queue head
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_tag_a[i]  = in_tag[i*TAG_WIDTH +: TAG_WIDTH];
            in_lo_a[i]   = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            in_hi_a[i]   = in_data_hi[i*DATA_WIDTH +: DATA_WIDTH];
            head_tag[i]  = tag_mem[i][rd_ptr_q[i]];
            head_lo[i]   = lo_mem[i][rd_ptr_q[i]];
            head_hi[i]   = hi_mem[i][rd_ptr_q[i]];
            head_wide[i] = wide_mem[i][rd_ptr_q[i]];
        end
    end

    // Round-robin search: first candidate at or above rr_ptr, wrapping
    always_comb begin
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i] = (cnt_q[i] != '0);
        end
`ifdef CDB_BYPASS_EN
        for (int i = 0; i < NUM_SRC; i++) begin
            byp_cand[i] = (cnt_q[i] == '0) && in_valid[i];
        end
        cand = cand | byp_cand;
`endif
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!win_found && cand[(int'(rr_ptr_q) + k) % NUM_SRC]) begin
                win_found = 1'b1;
                win_idx   = SW'((int'(rr_ptr_q) + k) % NUM_SRC);
            end
        end
    end

    // Winner payload: queue head, or the live input when bypassing
    always_comb begin
        win_byp  = 1'b0;
        win_tag  = head_tag[win_idx];
        win_lo   = head_lo[win_idx];
        win_wide = head_wide[win_idx];
`ifdef CDB_BYPASS_EN
        if (win_found && byp_cand[win_idx]) begin
            win_byp  = 1'b1;
            win_tag  = in_tag_a[win_idx];
            win_lo   = in_lo_a[win_idx];
            win_wide = in_wide[win_idx];
        end
`endif
    end

    // Grant FSM: decides output beat, pops, pointer advance and push suppression
    always_comb begin
        state_d     = state_q;
        sec_src_d   = sec_src_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_hi_d    = cdb_hi_q;
        cdb_src_d   = cdb_src_q;
        pop_en      = '0;
        push_en     = in_valid & in_ready;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    cdb_valid_d = 1'b1;
                    cdb_tag_d   = win_tag;
                    cdb_data_d  = win_lo;
                    cdb_hi_d    = 1'b0;
                    cdb_src_d   = win_idx;
                    if (win_wide) begin
                        // Head stays put; a bypassed wide entry is still
                        // written so SECOND can read its high word from the head
                        state_d   = ST_SECOND;
                        sec_src_d = win_idx;
                    end else begin
                        rr_ptr_d = (win_idx == SW'(NUM_SRC - 1)) ? '0 : win_idx + SW'(1);
                        if (win_byp) begin
                            push_en[win_idx] = 1'b0;
                        end else begin
                            pop_en[win_idx] = 1'b1;
                        end
                    end
                end
            end
            ST_SECOND: begin
                cdb_valid_d     = 1'b1;
                cdb_tag_d       = head_tag[sec_src_q];
                cdb_data_d      = head_hi[sec_src_q];
                cdb_hi_d        = 1'b1;
                cdb_src_d       = sec_src_q;
                pop_en[sec_src_q] = 1'b1;
                rr_ptr_d        = (sec_src_q == SW'(NUM_SRC - 1)) ? '0 : sec_src_q + SW'(1);
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next queue pointers and occupancy; pointers wrap at the power-of-2 depth
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push_en[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop_en[i]);
            cnt_d[i]    = cnt_q[i] + CW'(push_en[i]) - CW'(pop_en[i]);
        end
    end

    // Queue storage write; contents need no reset since counts gate reads
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push_en[i]) begin
                tag_mem[i][wr_ptr_q[i]]  <= in_tag_a[i];
                lo_mem[i][wr_ptr_q[i]]   <= in_lo_a[i];
                hi_mem[i][wr_ptr_q[i]]   <= in_hi_a[i];
                wide_mem[i][wr_ptr_q[i]] <= in_wide[i];
            end
        end
    end

    // Queue pointer/count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    // FSM, round-robin pointer and registered CDB outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sec_src_q   <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_hi_q    <= 1'b0;
            cdb_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            sec_src_q   <= sec_src_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_hi_q    <= cdb_hi_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_hi    = cdb_hi_q;
    assign cdb_src   = cdb_src_q;

endmodule
`default_nettype wire
